dma_engine: RTL
===============

# dma_engine

Block-copy engine behind the memory map's DMA register window (0x4804–0x4807). The CPU programs a 24-bit source address in external ROM, a 16-bit destination in the internal memory space (program RAM, sprite/tile/palette VRAM, sound registers) and a word count. The engine then stalls the CPU, fetches each word over a req/ack source port and writes it through the shared memory bus. It drops the stall when the count reaches zero.

## Interface
Parameters:
- SRC_W, 24, source address width (SRC_U supplies bits 23:16)
- CNT_W, 16, word-count width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- dma_en  in  1  CPU access targets the DMA window
- dma_mode  in  2  register select: 0 SRC_L, 1 SRC_U, 2 DST, 3 AMT
- memwrite  in  1  CPU write strobe
- writedata  in  16  CPU write data
- rd_data  out  16  register readback
- busy  out  1  transfer in progress
- cpu_stall  out  1  freezes the CPU and gives it no bus access
- done  out  1  one-cycle pulse when a transfer completes
- src_req  out  1  source fetch request
- src_addr  out  SRC_W  source word address
- src_ack  in  1  source data valid
- src_data  in  16  source word
- bus_addr  out  16  memory bus address while busy
- bus_wdata  out  16  memory bus write data
- bus_write  out  1  memory bus write strobe

## Operation
- Register writes happen when dma_en && memwrite && !busy. Writes while busy are ignored.
  - Mode 0 loads src[15:0]. Mode 1 loads src[23:16] from writedata[7:0].
  - Mode 2 loads dst. Mode 3 loads cnt.
- Start condition: a mode-3 write with writedata != 0 starts a transfer. A mode-3 write of 0 loads cnt=0 and starts nothing, with no done pulse.
- Readback is combinational and returns 0 when !dma_en:
  - mode 0: src[15:0]
  - mode 1: {busy, 7'b0, src[23:16]}
  - mode 2: current dst
  - mode 3: remaining cnt
- The FSM has four states: IDLE, FETCH, WRITE, FINISH.
  - IDLE: wait for start. On start, go to FETCH.
  - FETCH: hold src_req=1 and src_addr=src. When src_ack=1, capture src_data into the data register and go to WRITE.
  - WRITE: drive bus_write=1, bus_addr=dst, bus_wdata=data. Then increment src and dst and decrement cnt. If the new cnt is 0, go to FINISH; otherwise go to FETCH.
  - FINISH: done=1 for this cycle, then go to IDLE.
- busy = cpu_stall = (state != IDLE).
- Arithmetic: src wraps modulo 2^24 and dst wraps modulo 2^16 (0xFFFF → 0x0000). cnt never underflows.
- src_ack is ignored outside FETCH.
- Reset (rst=0) at any time, including mid-transfer, gives:
  - state IDLE
  - src, dst, cnt and the data register all 0
  - every output 0 in the next cycle (src_req drops immediately, with no partial write).

## Timing
- Reset values of all outputs: rd_data 0, busy 0, cpu_stall 0, done 0, src_req 0, src_addr 0, bus_addr 0, bus_wdata 0, bus_write 0.
- Start: an AMT write in cycle N gives busy=cpu_stall=src_req=1 in cycle N+1.
- Per word: FETCH lasts (ack latency + 1) cycles, then WRITE lasts 1 cycle. With src_ack in the first FETCH cycle, the minimum is 2 cycles/word.
- A transfer of n words at zero wait costs 2n+1 stalled cycles including FINISH. busy falls in the cycle after FINISH.
- bus_write is exactly one cycle per word and never asserts outside WRITE.
- src_addr and bus_addr are registered outputs. They are stable during the whole of FETCH and WRITE respectively.

## Structure
- Shared package blue_dma_pkg holds:
  - state enum {IDLE, FETCH, WRITE, FINISH}
  - mode constants DMA_MODE_SRC_L/SRC_U/DST/AMT (0..3)
  - DMA_REGS base 16'h4804
- No sub-module: the register file and FSM live in one module. The memory controller muxes bus_* over the CPU path when cpu_stall=1.

## Test plan
- Program src=0x01_2340, dst=0x2000, amt=3, with ack on the first request cycle → three writes to 0x2000..0x2002 carrying the ROM words at 0x012340..0x012342. busy is high for 7 cycles, done pulses once, and readback cnt=0, dst=0x2003.
- Random src_ack delays of 0–5 cycles on amt=4 → src_addr stays held until ack, write data matches each acked word, and no extra bus_write occurs.
- dst=0xFFFF, src=0xFF_FFFF, amt=2 → second write goes to 0x0000 and second fetch goes to 0x000000.
- AMT write of 0 → busy stays 0 and there is no done pulse. A DST write during busy → dst keeps its incrementing value.
- rst low during the FETCH of word 2 of 5 → next cycle busy=0, src_req=0, no write for word 2, all registers 0.
- Readback mode 1 while busy → bit15=1 and low byte = src[23:16].

Source files
------------

// File: rtl/blue_dma_pkg.sv
// Shared DMA types and constants.
// Register window base and FSM state encoding.
package blue_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    FINISH
  } dma_state_e;

  localparam logic [1:0] DMA_MODE_SRC_L = 2'd0;
  localparam logic [1:0] DMA_MODE_SRC_U = 2'd1;
  localparam logic [1:0] DMA_MODE_DST   = 2'd2;
  localparam logic [1:0] DMA_MODE_AMT   = 2'd3;

  localparam logic [15:0] DMA_REGS = 16'h4804;

endpackage

// File: rtl/dma_engine.sv
// ROM-to-internal-memory block copy engine.
// Stalls the CPU while words are fetched and written.
module dma_engine #(
  parameter int SRC_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dma_en,
  input  logic [1:0]       dma_mode,
  input  logic             memwrite,
  input  logic [15:0]      writedata,
  output logic [15:0]      rd_data,
  output logic             busy,
  output logic             cpu_stall,
  output logic             done,
  output logic             src_req,
  output logic [SRC_W-1:0] src_addr,
  input  logic             src_ack,
  input  logic [15:0]      src_data,
  output logic [15:0]      bus_addr,
  output logic [15:0]      bus_wdata,
  output logic             bus_write
);

  import blue_dma_pkg::*;

  dma_state_e       state;
  dma_state_e       state_nxt;
  logic [SRC_W-1:0] src;
  logic [15:0]      dst;
  logic [15:0]      data;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] amt_in;
  logic [7:0]       src_u;
  logic             reg_wr;
  logic             start;
  logic             last;

  assign amt_in = CNT_W'(writedata);
  assign reg_wr = dma_en & memwrite & ~busy;
  assign start  = reg_wr
                & (dma_mode == DMA_MODE_AMT)
                & (amt_in != '0);
  assign last   = (cnt <= CNT_W'(1));
  assign src_u  = 8'(src[SRC_W-1:16]);

  assign src_addr  = src;
  assign bus_addr  = dst;
  assign bus_wdata = data;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    src_req   = 1'b0;
    bus_write = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        src_req = 1'b1;
        if (src_ack) state_nxt = WRITE;
      end
      WRITE: begin
        bus_write = 1'b1;
        state_nxt = last ? FINISH : FETCH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  assign cpu_stall = busy;

  // Register file and transfer datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      src  <= '0;
      dst  <= '0;
      cnt  <= '0;
      data <= '0;
    end else begin
      if (reg_wr) begin
        unique case (dma_mode)
          DMA_MODE_SRC_L: src[15:0] <= writedata;
          DMA_MODE_SRC_U:
            src[SRC_W-1:16] <= writedata[SRC_W-17:0];
          DMA_MODE_DST:   dst <= writedata;
          DMA_MODE_AMT:   cnt <= amt_in;
        endcase
      end
      if (state == FETCH && src_ack) data <= src_data;
      if (state == WRITE) begin
        src <= src + SRC_W'(1);
        dst <= dst + 16'd1;
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Combinational register readback.
  always_comb begin
    rd_data = '0;
    if (dma_en) begin
      unique case (dma_mode)
        DMA_MODE_SRC_L: rd_data = src[15:0];
        DMA_MODE_SRC_U: rd_data = {busy, 7'b0, src_u};
        DMA_MODE_DST:   rd_data = dst;
        DMA_MODE_AMT:   rd_data = 16'(cnt);
      endcase
    end
  end

endmodule
